mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I core, sitting between the execute stage and the write-back stage. It accepts one instruction at a time from execute and issues loads and stores to the data memory over a req/ack handshake. It aligns and sign- or zero-extends load data, and forms store byte enables and lane-replicated write data. It presents a registered result bundle (valid, rd, write enable, data, fault) to write-back, and stalls execute while a memory transaction is outstanding.

## Interface
- XLEN, 32, datapath and address width; only 32 is supported.
- RA_W, 5, register-address width.

- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_alu_result  in  XLEN  ALU result; this is the effective address for loads and stores.
- ex_rs2_data  in  XLEN  store source data.
- ex_rd  in  RA_W  destination register.
- ex_reg_we  in  1  instruction writes rd.
- ex_mem_re  in  1  instruction is a load.
- ex_mem_we  in  1  instruction is a store. ex_mem_re and ex_mem_we are never both 1.
- ex_funct3  in  3  load/store size code.
- mem_ready  out  1  stage can accept an instruction this cycle.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  word address; bits [1:0] are always 0.
- dmem_be  out  4  store byte enables; 0000 for loads.
- dmem_wdata  out  XLEN  store data, lane-replicated.
- dmem_ack  in  1  memory completes the request; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  XLEN  load word.
- wb_valid  out  1  result bundle valid, for exactly one cycle per instruction.
- wb_rd  out  RA_W  destination register.
- wb_reg_we  out  1  write enable to the register file.
- wb_wdata  out  XLEN  write-back data.
- wb_fault  out  1  misaligned access or illegal funct3.

## Operation
- FSM states: IDLE and BUSY. mem_ready = (state == IDLE).
- Accept: an instruction is accepted when ex_valid && mem_ready.
- Non-memory instruction (re = we = 0), on accept:
  - next cycle: wb_valid=1, wb_wdata=ex_alu_result, wb_rd=ex_rd, wb_reg_we=ex_reg_we.
  - stays in IDLE.
- Memory instruction, on accept:
  - captures offset a=addr[1:0], funct3, rd, reg_we and direction.
  - runs the fault check (below). If there is no fault: registers the dmem_* outputs and moves to BUSY.
- Fault conditions:
  - LH/LHU/SH with a[0]=1.
  - LW/SW with a≠0.
  - load funct3 ∈ {011, 110, 111}.
  - store funct3 ∉ {000, 001, 010}.
- Faulting instruction:
  - no memory request is issued and the stage stays in IDLE.
  - next cycle: wb_valid=1, wb_fault=1, wb_reg_we=0, wb_wdata=0.
- BUSY state:
  - dmem_req=1 and all dmem_* outputs are held stable until the cycle in which dmem_ack=1.
  - on that edge: wb bundle is registered (wb_valid=1 next cycle), dmem_req drops, state returns to IDLE.
- Store byte enables and data:
  - SB: be=0001<<a, wdata={4{rs2[7:0]}}.
  - SH: be=0011<<a, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Store write-back: wb_reg_we=0, wb_wdata=0.
- Load lane select: byte b=rdata[8a+7:8a]; half h=rdata[8a+15:8a].
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h.
  - LW: rdata.
- rd==0: wb_reg_we is forced to 0; wb_valid is unaffected.
- dmem_ack while in IDLE is ignored.
- ex_* inputs are not sampled while in BUSY.

## Timing
- Reset values: state=IDLE; wb_valid, wb_reg_we, wb_fault, dmem_req, dmem_we = 0; wb_rd, wb_wdata, dmem_addr, dmem_be, dmem_wdata = 0. mem_ready=1 in the first cycle after reset.
- Reset asserted during BUSY abandons the transaction: dmem_req=0 after that edge and no wb_valid is produced for it.
- ALU op or fault accepted at edge N: wb_valid high during cycle N+1. Back-to-back acceptance every cycle is allowed.
- Memory op accepted at edge N: dmem_req is high from cycle N+1. With ack sampled at edge M (M ≥ N+1):
  - wb_valid is high in cycle M+1.
  - mem_ready is high in cycle M+1.
  - the next instruction is accepted no earlier than edge M+1.
- Zero-wait memory (ack=1 in the first request cycle): load-to-wb latency is 2 cycles; throughput is one memory op per 2 cycles.
- wb_valid is a single-cycle pulse. It is 0 in any cycle without a completion.

## Test plan
- ALU pass-through: ex_alu_result=0x1234_5678, rd=5, reg_we=1, three consecutive cycles. Expect wb_valid high on three consecutive cycles with wb_wdata=0x1234_5678, and mem_ready high throughout.
- LB/LBU at addr 0x103, dmem_rdata=0x80FF_0000, ack after 3 wait cycles:
  - dmem_addr=0x100 and dmem_req held high 4 cycles.
  - LB gives wb_wdata=0xFFFF_FF80; LBU gives 0x0000_0080.
  - mem_ready low while BUSY.
- SH at addr 0x202, rs2=0xAAAA_BEEF, zero-wait: dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, then wb_valid with wb_reg_we=0.
- Misaligned LW at addr 0x06: no dmem_req. Next cycle: wb_valid=1, wb_fault=1, wb_reg_we=0.
- LW to rd=0 with rdata=0xDEAD_BEEF: wb_valid=1, wb_reg_we=0.
- rst pulsed while BUSY awaiting ack: dmem_req=0 and all outputs at reset values after the edge; a spurious later ack produces no wb_valid.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mem_stage
// Description : RV32I memory-access stage. Accepts one instruction at a time
//               from execute and issues loads/stores over a req/ack
//               handshake. Aligns and extends load data, builds store byte
//               enables and lane-replicated store data, and presents a
//               registered one-cycle result bundle to write-back.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module mem_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    // execute-stage interface
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_reg_we,
    input  logic            ex_mem_re,
    input  logic            ex_mem_we,
    input  logic [2:0]      ex_funct3,
    output logic            mem_ready,
    // data-memory interface
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    // write-back interface
    output logic            wb_valid,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_reg_we,
    output logic [XLEN-1:0] wb_wdata,
    output logic            wb_fault
);

    // Size codes shared by loads and stores (funct3[1:0]); bit 2 marks unsigned loads.
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Instruction context captured at accept, used when the ack arrives.
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic [RA_W-1:0] r_rd;
    logic            r_load_we;

    logic            w_accept;
    logic            w_is_mem;
    logic [1:0]      w_off;
    logic            w_fault;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_ld_data;

    assign mem_ready = (r_state == IDLE);
    assign w_accept  = ex_valid && mem_ready;
    assign w_is_mem  = ex_mem_re || ex_mem_we;
    assign w_off     = ex_alu_result[1:0];

    // Alignment and funct3 legality check on the incoming instruction.
    always_comb begin
        w_fault = 1'b0;
        if (ex_mem_re) begin
            case (ex_funct3)
                3'b000, 3'b100: w_fault = 1'b0;
                3'b001, 3'b101: w_fault = w_off[0];
                3'b010:         w_fault = (w_off != 2'b00);
                default:        w_fault = 1'b1;
            endcase
        end else if (ex_mem_we) begin
            case (ex_funct3)
                3'b000:  w_fault = 1'b0;
                3'b001:  w_fault = w_off[0];
                3'b010:  w_fault = (w_off != 2'b00);
                default: w_fault = 1'b1;
            endcase
        end
    end

    // Store byte enables and lane-replicated store data.
    always_comb begin
        w_be      = 4'b0000;
        w_st_data = ex_rs2_data;
        case (ex_funct3[1:0])
            c_SZ_BYTE: begin
                w_be      = 4'b0001 << w_off;
                w_st_data = {4{ex_rs2_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_be      = 4'b0011 << w_off;
                w_st_data = {2{ex_rs2_data[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_st_data = ex_rs2_data;
            end
        endcase
    end

    // Load lane select: shift the addressed byte/half down to bit 0, then extend.
    assign w_shifted = dmem_rdata >> {r_off, 3'b000};

    // Load extension by size and signedness.
    always_comb begin
        w_ld_data = '0;
        case (r_funct3)
            3'b000:  w_ld_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b001:  w_ld_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            3'b010:  w_ld_data = dmem_rdata;
            default: w_ld_data = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a legal memory op enters BUSY, the ack returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mem && !w_fault) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Memory request and result bundle registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_reg_we  <= 1'b0;
            wb_wdata   <= '0;
            wb_fault   <= 1'b0;
            r_off      <= 2'b00;
            r_funct3   <= 3'b000;
            r_rd       <= '0;
            r_load_we  <= 1'b0;
        end else begin
            // wb_valid is a single-cycle pulse unless a completion happens now.
            wb_valid <= 1'b0;
            wb_fault <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    if (!w_is_mem) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= ex_rd;
                        wb_reg_we <= ex_reg_we && (ex_rd != '0);
                        wb_wdata  <= ex_alu_result;
                    end else if (w_fault) begin
                        wb_valid  <= 1'b1;
                        wb_fault  <= 1'b1;
                        wb_rd     <= ex_rd;
                        wb_reg_we <= 1'b0;
                        wb_wdata  <= '0;
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_we;
                        dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
                        dmem_be    <= ex_mem_we ? w_be : 4'b0000;
                        dmem_wdata <= w_st_data;
                        r_off      <= w_off;
                        r_funct3   <= ex_funct3;
                        r_rd       <= ex_rd;
                        r_load_we  <= ex_mem_re && ex_reg_we && (ex_rd != '0);
                    end
                end
            end else if (dmem_ack) begin
                dmem_req  <= 1'b0;
                wb_valid  <= 1'b1;
                wb_rd     <= r_rd;
                wb_reg_we <= r_load_we;
                wb_wdata  <= dmem_we ? '0 : w_ld_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed scenarios plus
//               randomized ALU/load/store traffic against a byte-level
//               reference model with a randomly stalling memory responder.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [2:0]  ex_funct3;
    logic        mem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic [31:0] wb_wdata;
    logic        wb_fault;

    int n_checks = 0;
    int n_err    = 0;

    mem_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_rs2_data   (ex_rs2_data),
        .ex_rd         (ex_rd),
        .ex_reg_we     (ex_reg_we),
        .ex_mem_re     (ex_mem_re),
        .ex_mem_we     (ex_mem_we),
        .ex_funct3     (ex_funct3),
        .mem_ready     (mem_ready),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_reg_we     (wb_reg_we),
        .wb_wdata      (wb_wdata),
        .wb_fault      (wb_fault)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_fault(input bit re, input bit we, input logic [2:0] f3,
                                     input logic [31:0] addr);
        if (!re && !we) return 1'b0;
        if (f3[1:0] == 2'b11) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (re && f3 == 3'b110) return 1'b1;
        return (addr % op_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int     sz = op_size(f3);
        int     a  = int'(addr % 4);
        longint v  = 0;
        for (int i = 0; i < sz; i++) begin
            v += longint'((word >> (8 * (a + i))) & 32'hFF) << (8 * i);
        end
        if (!f3[2] && sz < 4 && v >= (64'sd1 <<< (8 * sz - 1))) begin
            v -= (64'sd1 <<< (8 * sz));
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = op_size(f3);
        int a  = int'(addr % 4);
        return 4'(((1 << sz) - 1) << a);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int          sz = op_size(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = 8'(rs2 >> (8 * (i % sz)));
        end
        return w;
    endfunction

    // ---------------- stimulus tasks ----------------
    // One instruction from issue to its write-back completion.
    task automatic run_op(input bit re, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [4:0] rd, input bit reg_we,
                          input logic [31:0] rdata, input int waits);
        bit          flt;
        bit          is_mem;
        logic [31:0] exp_data;
        ex_valid      = 1'b1;
        ex_alu_result = addr;
        ex_rs2_data   = rs2;
        ex_rd         = rd;
        ex_reg_we     = reg_we;
        ex_mem_re     = re;
        ex_mem_we     = we;
        ex_funct3     = f3;
        chk("ready_at_issue", 32'(mem_ready), 32'd1);
        @(posedge clk); #1;
        ex_valid  = 1'b0;
        ex_alu_result = $urandom;
        flt       = ref_fault(re, we, f3, addr);
        is_mem    = (re || we) && !flt;
        if (is_mem) begin
            for (int w = 0; w <= waits; w++) begin
                chk("busy_req", 32'(dmem_req), 32'd1);
                chk("busy_addr", dmem_addr, {addr[31:2], 2'b00});
                chk("busy_we", 32'(dmem_we), 32'(we));
                chk("busy_be", 32'(dmem_be), we ? 32'(ref_be(f3, addr)) : 32'd0);
                if (we) chk("busy_wdata", dmem_wdata, ref_wdata(f3, rs2));
                chk("busy_ready", 32'(mem_ready), 32'd0);
                chk("busy_wbvalid", 32'(wb_valid), 32'd0);
                dmem_ack   = (w == waits);
                dmem_rdata = (w == waits) ? rdata : $urandom;
                @(posedge clk); #1;
            end
            dmem_ack = 1'b0;
            chk("done_ready", 32'(mem_ready), 32'd1);
        end
        chk("done_req", 32'(dmem_req), 32'd0);
        exp_data = flt ? 32'd0 : we ? 32'd0 : re ? ref_load(f3, addr, rdata) : addr;
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_fault", 32'(wb_fault), 32'(flt));
        chk("wb_reg_we", 32'(wb_reg_we), 32'(!flt && !we && reg_we && rd != 0));
        chk("wb_wdata", wb_wdata, exp_data);
    endtask

    // A cycle with nothing issued: no completion may appear.
    task automatic idle_check();
        ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_wbvalid", 32'(wb_valid), 32'd0);
        chk("idle_ready", 32'(mem_ready), 32'd1);
    endtask

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Main sequence.
    initial begin
        bit          re;
        bit          we;
        logic [4:0]  rd;
        int          kind;
        rst = 1'b1;
        ex_valid = 1'b0; ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0;
        ex_reg_we = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_funct3 = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(mem_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wbvalid", 32'(wb_valid), 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);

        // ALU pass-through, three back-to-back accepts
        ex_valid = 1'b1; ex_alu_result = 32'h1234_5678; ex_rd = 5'd5; ex_reg_we = 1'b1;
        ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_funct3 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_valid", 32'(wb_valid), 32'd1);
            chk("b2b_wdata", wb_wdata, 32'h1234_5678);
            chk("b2b_rd", 32'(wb_rd), 32'd5);
            chk("b2b_ready", 32'(mem_ready), 32'd1);
        end
        idle_check();

        // LB / LBU at 0x103 with 3 wait cycles
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_0000, 3);
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 5'd8, 1, 32'h80FF_0000, 3);
        chk("lbu_direct", wb_wdata, 32'h0000_0080);
        // SH at 0x202, zero-wait
        run_op(0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd3, 0, 32'h0, 0);
        // Misaligned LW
        run_op(1, 0, 3'b010, 32'h06, 32'h0, 5'd9, 1, 32'h0, 0);
        idle_check();
        // LW to x0
        run_op(1, 0, 3'b010, 32'h40, 32'h0, 5'd0, 1, 32'hDEAD_BEEF, 1);
        idle_check();

        // Reset while BUSY abandons the transaction
        ex_valid = 1'b1; ex_alu_result = 32'h80; ex_rd = 5'd4; ex_reg_we = 1'b1;
        ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("rb_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rb_req_after", 32'(dmem_req), 32'd0);
        chk("rb_we_after", 32'(dmem_we), 32'd0);
        chk("rb_addr_after", dmem_addr, 32'd0);
        chk("rb_be_after", 32'(dmem_be), 32'd0);
        chk("rb_wdata_after", dmem_wdata, 32'd0);
        chk("rb_wbvalid_after", 32'(wb_valid), 32'd0);
        chk("rb_ready_after", 32'(mem_ready), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("spurious_ack_valid", 32'(wb_valid), 32'd0);
            chk("spurious_ack_req", 32'(dmem_req), 32'd0);
        end
        dmem_ack = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 2));
            re   = (kind == 1);
            we   = (kind == 2);
            rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            run_op(re, we, 3'($urandom), $urandom, $urandom, rd, 1'($urandom),
                   $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_check();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
